// File: rtl/ncc_op_sequencer.sv
// ncc_op_sequencer: Ncc-Sign load/compute/unload control FSM; define NCC_SEQ_CYCCNT_EN to enable oCYC_CNT
module ncc_op_sequencer #(
  parameter int PRM_DAXI = 64,
  parameter int PRM_ADDR = 12,
  parameter int PRM_N = 4096,
  parameter int PRM_KBEATS = 25
) (
  input logic iSYS_CLK,
  input logic iSYS_RST,
  input logic [1:0] iCTL_MODE,
  input logic [1:0] iCTL_BUT,
  input logic [1:0] iCTL_Q,
  input logic [3:0] iCTL_NTTDEPTH,
  input logic iCTL_START,
  output logic oCTL_BUSY,
  output logic oCTL_DONE,
  output logic oCTL_ERR,
  input logic iS_TVALID,
  input logic iS_TLAST,
  output logic oS_TREADY,
  output logic oWR_EN,
  output logic oWR_BANK,
  output logic [PRM_ADDR-1:0] oWR_ADDR,
  output logic oENG_START,
  output logic [3:0] oENG_STAGE,
  output logic [1:0] oENG_BUT,
  output logic [1:0] oENG_Q,
  input logic iENG_DONE,
  output logic oRD_EN,
  output logic [PRM_ADDR-1:0] oRD_ADDR,
  output logic oM_TVALID,
  output logic oM_TLAST,
  input logic iM_TREADY,
  output logic [31:0] oCYC_CNT
);
  localparam int CW = PRM_ADDR + 1;
  localparam int LOG2N = $clog2(PRM_N);
  localparam logic [CW-1:0] PBEATS = CW'(PRM_N / (PRM_DAXI / 32));
  localparam logic [CW-1:0] KBEATS = CW'(PRM_KBEATS);
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_WAIT, S_UNLOAD, S_DONE} state_t;
  state_t state, state_n, after_load;
  logic [1:0] mode, but, q;
  logic [3:0] depth, stg, stages;
  logic [CW-1:0] cnt, rd_cnt, m_idx, beats;
  logic m_valid, err, rej_done, ok_cmd, accept, pwm, s_acc, s_last, m_end;
  assign ok_cmd = (iCTL_MODE == 2'd1 || iCTL_MODE == 2'd2) && iCTL_BUT != 2'd3;
  assign accept = state == S_IDLE && iCTL_START && ok_cmd;
  assign pwm = mode == 2'd2 && but == 2'd0;
  assign beats = (mode == 2'd1) ? KBEATS : PBEATS;
  assign stages = (mode == 2'd1 || but == 2'd0) ? 4'd1 : ((depth > 4'(LOG2N)) ? 4'(LOG2N) : depth);
  assign s_acc = oS_TREADY && iS_TVALID;
  assign s_last = cnt == beats - 1'b1;
  assign m_end = state == S_UNLOAD && m_valid && iM_TREADY && m_idx == beats - 1'b1;
  assign after_load = (state == S_LOAD_A && pwm) ? S_LOAD_B : ((stages == 4'd0) ? S_UNLOAD : S_RUN);
  always_ff @(posedge iSYS_CLK)
    state <= iSYS_RST ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = accept ? S_LOAD_A : S_IDLE;
      S_LOAD_A, S_LOAD_B: if (s_acc) state_n = s_last ? after_load : (iS_TLAST ? S_DONE : state);
      S_RUN: state_n = S_WAIT;
      S_WAIT: if (iENG_DONE) state_n = (stg + 4'd1 < stages) ? S_RUN : S_UNLOAD;
      S_UNLOAD: if (m_end) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    oCTL_BUSY = state != S_IDLE;
    oCTL_DONE = (state == S_DONE) || rej_done;
    oCTL_ERR = err;
    oS_TREADY = state == S_LOAD_A || state == S_LOAD_B;
    oWR_EN = oS_TREADY && iS_TVALID;
    oWR_BANK = state == S_LOAD_B;
    oWR_ADDR = cnt[PRM_ADDR-1:0];
    oENG_START = state == S_RUN;
    oENG_STAGE = stg;
    oENG_BUT = but;
    oENG_Q = q;
    oRD_EN = state == S_UNLOAD && rd_cnt < beats && (!m_valid || iM_TREADY);
    oRD_ADDR = rd_cnt[PRM_ADDR-1:0];
    oM_TVALID = m_valid;
    oM_TLAST = m_valid && m_idx == beats - 1'b1;
  end
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      mode <= '0;
      but <= '0;
      q <= '0;
      depth <= '0;
      stg <= '0;
      cnt <= '0;
      rd_cnt <= '0;
      m_idx <= '0;
      m_valid <= 1'b0;
      err <= 1'b0;
      rej_done <= 1'b0;
    end else begin
      rej_done <= state == S_IDLE && iCTL_START && !ok_cmd;
      if (accept) begin
        mode <= iCTL_MODE;
        but <= iCTL_BUT;
        q <= iCTL_Q;
        depth <= iCTL_NTTDEPTH;
        stg <= '0;
        cnt <= '0;
        rd_cnt <= '0;
        m_valid <= 1'b0;
        err <= 1'b0;
      end else if (state == S_IDLE && iCTL_START) err <= 1'b1;
      if (s_acc) begin
        cnt <= s_last ? '0 : cnt + 1'b1;
        if (s_last ? !iS_TLAST : iS_TLAST) err <= 1'b1;
        if (s_last && after_load == S_UNLOAD) err <= 1'b1;
      end
      if (state == S_WAIT && iENG_DONE && stg + 4'd1 < stages) stg <= stg + 4'd1;
      if (oRD_EN) begin
        rd_cnt <= rd_cnt + 1'b1;
        m_idx <= rd_cnt;
        m_valid <= 1'b1;
      end else if (iM_TREADY) m_valid <= 1'b0;
    end
  end
`ifdef NCC_SEQ_CYCCNT_EN
  logic [31:0] cyc;
  always_ff @(posedge iSYS_CLK)
    if (iSYS_RST || accept) cyc <= '0;
    else if (oCTL_BUSY && cyc != '1) cyc <= cyc + 1'b1;
  assign oCYC_CNT = cyc;
`else
  assign oCYC_CNT = '0;
`endif
endmodule
